// File: rtl/bcd_counter_pkg.sv
// Shared types and elaboration-time helpers for the BCD modulo counter.
// Values up to 8 BCD digits are handled in a fixed 32-bit container.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Binary integer to packed BCD (digit 0 in bits [3:0]).
    // Used at elaboration to form the terminal count.
    function automatic logic [31:0] to_bcd(input int value);
        logic [31:0] bcd;
        int          v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < 8; i++) begin
            bcd[i*4 +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return bcd;
    endfunction

    // True when every nibble of the vector is a legal BCD digit.
    function automatic logic bcd_valid(input logic [31:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vec[i*4 +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-step prescaler: produces a one-cycle step enable every TICK_DIV
// enabled clock cycles. It is a clock enable, never a derived clock.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = $clog2(TICK_DIV + 1)
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En,
    input  logic Clr,
    output logic Step
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] cnt_q, cnt_d;

    // Next phase and step strobe; the step fires on the last phase while enabled.
    always_comb begin
        cnt_d = cnt_q;
        Step  = 1'b0;
        if (Clr) begin
            cnt_d = '0;
        end else if (En) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                Step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Phase register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised multi-digit BCD modulo counter with tick prescaler,
// synchronous clear, validated parallel load and wrap pulse.
// Optional build macro COUNT_DOWN_EN adds a Dir input for down-counting.
module bcd_mod_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 24,
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = $clog2(TICK_DIV + 1)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                En,
    input  logic                Clr,
    input  logic                Load,
`ifdef COUNT_DOWN_EN
    input  logic                Dir,
`endif
    input  logic [4*DIGITS-1:0] LoadVal,
    output logic [4*DIGITS-1:0] Result,
    output logic                Tick,
    output logic                Carry,
    output logic                LoadErr
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MODULUS - 1));

    logic [W-1:0] result_q, result_d;
    logic         tick_q, tick_d;
    logic         carry_q, carry_d;
    logic         load_err_q, load_err_d;

    logic         load_ok;
    logic         step;

    // A load must be all-BCD and below the modulus; BCD order matches numeric order.
    assign load_ok = bcd_valid(32'(LoadVal)) && (LoadVal <= MAX_BCD);

    // Any Load (valid or not) discards a coinciding step, so the prescaler
    // is frozen during Load and restarted by Clr or an accepted Load.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RSTn (RSTn),
        .En   (En & ~Load),
        .Clr  (Clr | (Load & load_ok)),
        .Step (step)
    );

    // Ripple digit chain: digit i moves when every lower digit is at its limit.
    logic [DIGITS-1:0] up_en;
    logic [W-1:0]      up_val;
    assign up_en[0] = 1'b1;

`ifdef COUNT_DOWN_EN
    logic [DIGITS-1:0] dn_en;
    logic [W-1:0]      dn_val;
    assign dn_en[0] = 1'b1;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_t cur;
        assign cur = result_q[gi*4 +: 4];

        assign up_val[gi*4 +: 4] = !up_en[gi]       ? cur :
                                   (cur == BCD_MAX) ? 4'd0 : cur + 4'd1;
        if (gi + 1 < DIGITS) begin : g_up_chain
            assign up_en[gi+1] = up_en[gi] & (cur == BCD_MAX);
        end

`ifdef COUNT_DOWN_EN
        assign dn_val[gi*4 +: 4] = !dn_en[gi]   ? cur :
                                   (cur == 4'd0) ? BCD_MAX : cur - 4'd1;
        if (gi + 1 < DIGITS) begin : g_dn_chain
            assign dn_en[gi+1] = dn_en[gi] & (cur == 4'd0);
        end
`endif
    end

    // Next count and pulses, priority Clr > Load > step.
    always_comb begin
        result_d   = result_q;
        tick_d     = 1'b0;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (Clr) begin
            result_d = '0;
        end else if (Load) begin
            if (load_ok) begin
                result_d = LoadVal;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step) begin
            tick_d = 1'b1;
`ifdef COUNT_DOWN_EN
            if (Dir) begin
                if (result_q == '0) begin
                    result_d = MAX_BCD;
                    carry_d  = 1'b1;
                end else begin
                    result_d = dn_val;
                end
            end else
`endif
            if (result_q == MAX_BCD) begin
                result_d = '0;
                carry_d  = 1'b1;
            end else begin
                result_d = up_val;
            end
        end
    end

    // Count and pulse registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            result_q   <= '0;
            tick_q     <= 1'b0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            tick_q     <= tick_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign Result  = result_q;
    assign Tick    = tick_q;
    assign Carry   = carry_q;
    assign LoadErr = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter: integer reference model for the
// 2-digit mod-24 /4 instance checked every cycle, directed literal checks,
// randomized stimulus, and two auxiliary instances for wrap boundaries.
module tb_bcd_mod_counter;

    logic       CLK = 1'b0;
    logic       RSTn, En, Clr, Load;
    logic [7:0] LoadVal;
    logic [7:0] Result;
    logic       Tick, Carry, LoadErr;

    // 3-digit mod-1000, step every enabled cycle
    logic        en3, load3;
    logic [11:0] lv3, res3;
    logic        tick3, carry3, err3;

    // 2-digit mod-60, step every enabled cycle
    logic        en60, load60;
    logic [7:0]  lv60, res60;
    logic        tick60, carry60, err60;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   m_val = 0;
    int   m_pre = 0;
    logic e_tick = 1'b0, e_carry = 1'b0, e_err = 1'b0;

    always #5 CLK = ~CLK;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .TICK_DIV(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .En(En), .Clr(Clr), .Load(Load),
        .LoadVal(LoadVal), .Result(Result), .Tick(Tick), .Carry(Carry),
        .LoadErr(LoadErr)
    );

    bcd_mod_counter #(.DIGITS(3), .MODULUS(1000), .TICK_DIV(1)) dut3 (
        .CLK(CLK), .RSTn(RSTn), .En(en3), .Clr(1'b0), .Load(load3),
        .LoadVal(lv3), .Result(res3), .Tick(tick3), .Carry(carry3),
        .LoadErr(err3)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .TICK_DIV(1)) dut60 (
        .CLK(CLK), .RSTn(RSTn), .En(en60), .Clr(1'b0), .Load(load60),
        .LoadVal(lv60), .Result(res60), .Tick(tick60), .Carry(carry60),
        .LoadErr(err60)
    );

    function automatic logic is_bcd2(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count value and prescaler phase as plain integers.
    always @(posedge CLK) begin
        e_tick  = 1'b0;
        e_carry = 1'b0;
        e_err   = 1'b0;
        if (!RSTn) begin
            m_val = 0;
            m_pre = 0;
        end else if (Clr) begin
            m_val = 0;
            m_pre = 0;
        end else if (Load) begin
            if (is_bcd2(LoadVal) && bcd2int(LoadVal) < 24) begin
                m_val = bcd2int(LoadVal);
                m_pre = 0;
            end else begin
                e_err = 1'b1;
            end
        end else if (En) begin
            if (m_pre == 3) begin
                m_pre  = 0;
                e_tick = 1'b1;
                if (m_val == 23) begin
                    m_val   = 0;
                    e_carry = 1'b1;
                end else begin
                    m_val = m_val + 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        check("model_result",  32'(Result),  32'(int2bcd(m_val)));
        check("model_tick",    32'(Tick),    32'(e_tick));
        check("model_carry",   32'(Carry),   32'(e_carry));
        check("model_loaderr", 32'(LoadErr), 32'(e_err));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input logic [7:0] v);
        Load = 1'b1; LoadVal = v;
        cycles(1);
        Load = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; En = 1'b1; Clr = 1'b0; Load = 1'b0; LoadVal = '0;
        en3 = 1'b0; load3 = 1'b0; lv3 = '0;
        en60 = 1'b0; load60 = 1'b0; lv60 = '0;
        cycles(3);
        check("reset_result",  32'(Result),  32'h00);
        check("reset_tick",    32'(Tick),    32'h0);
        check("reset_carry",   32'(Carry),   32'h0);
        check("reset_loaderr", 32'(LoadErr), 32'h0);
        RSTn = 1'b1;

        // 08 -> 09 -> 10, one step per 4 enabled cycles
        do_load(8'h08);
        check("load_08", 32'(Result), 32'h08);
        cycles(3);
        check("no_tick_yet", 32'(Tick), 32'h0);
        cycles(1);
        check("step_09", 32'(Result), 32'h09);
        check("tick_09", 32'(Tick), 32'h1);
        cycles(4);
        check("step_10", 32'(Result), 32'h10);
        En = 1'b0;
        cycles(10);
        check("hold_10", 32'(Result), 32'h10);
        En = 1'b1;

        // Wrap 23 -> 00 with Carry, then 01 without
        do_load(8'h23);
        cycles(4);
        check("wrap_00", 32'(Result), 32'h00);
        check("wrap_carry", 32'(Carry), 32'h1);
        cycles(4);
        check("after_wrap_01", 32'(Result), 32'h01);
        check("after_wrap_carry", 32'(Carry), 32'h0);

        // Load validation and Clr priority
        do_load(8'h17);
        check("load_17", 32'(Result), 32'h17);
        do_load(8'h24);
        check("bad_24_hold", 32'(Result), 32'h17);
        check("bad_24_err", 32'(LoadErr), 32'h1);
        do_load(8'h1A);
        check("bad_1A_hold", 32'(Result), 32'h17);
        check("bad_1A_err", 32'(LoadErr), 32'h1);
        Clr = 1'b1;
        do_load(8'h05);
        Clr = 1'b0;
        check("clr_load_00", 32'(Result), 32'h00);
        check("clr_load_err", 32'(LoadErr), 32'h0);

        // Auxiliary instances: full-range and mod-60 wrap
        load3 = 1'b1; lv3 = 12'h999; load60 = 1'b1; lv60 = 8'h59;
        cycles(1);
        load3 = 1'b0; load60 = 1'b0;
        check("d3_load_999", 32'(res3), 32'h999);
        check("d60_load_59", 32'(res60), 32'h59);
        en3 = 1'b1; en60 = 1'b1;
        cycles(1);
        check("d3_wrap_000", 32'(res3), 32'h000);
        check("d3_carry", 32'(carry3), 32'h1);
        check("d60_wrap_00", 32'(res60), 32'h00);
        check("d60_carry", 32'(carry60), 32'h1);
        cycles(1);
        check("d3_001", 32'(res3), 32'h001);
        check("d3_no_carry", 32'(carry3), 32'h0);
        check("d60_01", 32'(res60), 32'h01);
        en3 = 1'b0; en60 = 1'b0;
        load3 = 1'b1; lv3 = 12'h0A0;
        cycles(1);
        load3 = 1'b0;
        check("d3_bad_err", 32'(err3), 32'h1);
        check("d3_bad_hold", 32'(res3), 32'h001);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            RSTn = ($urandom_range(0, 199) != 0);
            En   = ($urandom_range(0, 3) != 0);
            Clr  = ($urandom_range(0, 49) == 0);
            Load = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 0) begin
                LoadVal = int2bcd($urandom_range(0, 23));
            end else begin
                LoadVal = 8'($urandom);
            end
            cycles(1);
        end
        RSTn = 1'b1; En = 1'b0; Clr = 1'b0; Load = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised multi-digit BCD modulo counter with an on-chip tick prescaler, for clock, timer and scoreboard displays. Successor to the fixed 2-digit 00–23 counter. Generalised in digit count, modulus and tick period. Adds count enable, synchronous clear, parallel load with validation, and a wrap (carry) pulse for cascading. Single clock domain: the prescaler produces a clock-enable, not a derived clock.

Parameters:
DIGITS, 2, number of BCD digits; Result width is 4*DIGITS; legal range 1–8.
MODULUS, 24, count range 0..MODULUS-1; legal range 2–10**DIGITS.
TICK_DIV, 50_000_000, CLK cycles per count step (1 s at 50 MHz); TICK_DIV=1 steps every enabled cycle.
PRE_W, $clog2(TICK_DIV+1), prescaler width; derived, not for override.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RSTn  input  1  synchronous, active-low reset.
En  input  1  count enable; low freezes prescaler and count.
Clr  input  1  synchronous clear of count and prescaler.
Load  input  1  parallel load strobe.
LoadVal  input  4*DIGITS  BCD value to load; digit 0 is bits [3:0].
Result  output  4*DIGITS  current count, BCD, digit 0 least significant.
Tick  output  1  one-cycle pulse when a count step is taken.
Carry  output  1  one-cycle pulse when Result wraps.
LoadErr  output  1  one-cycle pulse when a Load is rejected.

Behaviour:
- Reset (RSTn=0 at a CLK edge): Result=0, prescaler=0, Tick=0, Carry=0, LoadErr=0. Reset has no asynchronous effect.
- Priority, highest first: RSTn, Clr, Load, count step.
- Prescaler:
  - Counts 0..TICK_DIV-1 while En=1 and holds while En=0.
  - At TICK_DIV-1 with En=1, the prescaler returns to 0 and an internal step enable is asserted for that cycle.
  - Tick is registered and coincides with the cycle in which Result shows the new value.
- Count step:
  - Digit 0 increments on step enable.
  - Digit i (i>0) increments when all lower digits are 9; the lower digits then go to 0.
  - If Result == MODULUS-1 (as BCD), the next step loads 0 and Carry=1 in the same cycle as Result=0.
- Clr: Result=0 and prescaler=0 on the next edge. No Tick or Carry is generated.
- Load is valid only when every LoadVal digit is ≤9 and the value is < MODULUS.
  - Valid load: Result=LoadVal and prescaler=0, so the next step occurs TICK_DIV enabled cycles later.
  - Invalid load: Result and prescaler are unchanged; LoadErr=1 for one cycle.
- Clr and Load in the same cycle: Clr wins and LoadErr stays 0.
- Load coinciding with a step: the load wins, the step is discarded, Tick=0 and Carry=0.
- Result never holds a non-BCD digit or a value ≥ MODULUS.

Optional Feature:
COUNT_DOWN_EN
- Defined:
  - Adds input Dir (1 bit). Dir=0 counts up as above.
  - Dir=1 counts down: digit 0 decrements; digit i decrements when all lower digits are 0, and the lower digits then go to 9.
  - A step from 0 loads MODULUS-1 and pulses Carry (borrow).
  - Dir is sampled on the step cycle only.
- Undefined: no Dir port; up-count only; the down-count logic is absent.

Decomposition:
- Package bcd_counter_pkg:
  - typedef bcd_digit_t (4-bit).
  - constant BCD_MAX = 4'd9.
  - constant function to_bcd(int) used to form MODULUS-1 and the limit compare at elaboration.
  - function bcd_valid(vector) for load checking.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV.
  - Ports CLK, RSTn, En, Clr (Clr is ORed with valid Load by the parent).
  - Output step enable.
- Digit chain: generate loop in the parent.

Test Plan:
1. DIGITS=2, MODULUS=24, TICK_DIV=4; RSTn=0 for 3 cycles with En=1 → Result=0x00, Tick/Carry/LoadErr=0; Result changes only at a CLK edge.
2. En=1 from 0x08 → 0x09 then 0x10, with a Tick exactly every 4 cycles; En=0 for 10 cycles → Result and prescaler phase held.
3. Load 0x23, then run → next Tick gives Result=0x00 with a one-cycle Carry; the following Tick gives 0x01 with Carry=0.
4. Load 0x17 → 0x17 next cycle. Load 0x24 → unchanged, LoadErr pulse. Load 0x1A → unchanged, LoadErr pulse. Clr+Load 0x05 together → 0x00, LoadErr=0.
5. DIGITS=3, MODULUS=1000, TICK_DIV=1; load 0x999 → next cycle 0x000 with Carry. DIGITS=2, MODULUS=60; 0x59 → 0x00 with Carry.
6. COUNT_DOWN_EN defined, Dir=1, MODULUS=24, starting at 0x10 → 0x09 → … → 0x00 → 0x23 with Carry; Dir toggled between steps has no effect until the next step.
